// File: rtl/game_pkg.sv
// Shared types and widths for the game sequencer and its arbiter.
package game_pkg;

    localparam int unsigned SEED_W  = 4;
    localparam int unsigned MODE_W  = 2;
    localparam int unsigned DWELL_W = 4;
    localparam int unsigned HOLD_W  = 8;

    typedef logic [MODE_W-1:0] mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        OVER = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; bit 0 is player A, bit 1 is player B.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    // High when B took the most recent grant; reset value lets A win the first tie.
    logic last_b;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req == 2'b11) begin
                gnt = last_b ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_b <= 1'b1;
        end else if (en && (gnt != 2'b00)) begin
            last_b <= gnt[1];
        end
    end

endmodule

// File: rtl/game_sequencer.sv
// Sequences one full_game: seed load, mode changes by two arbitrated players,
// game-over detection and per-side score keeping.
module game_sequencer
    import game_pkg::*;
#(
    parameter int unsigned MIN_DWELL = 4,
    parameter int unsigned OVER_HOLD = 8,
    parameter int unsigned SCORE_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [SEED_W-1:0] start_seed,
    input  mode_t             start_mode,
    input  logic              a_req,
    input  mode_t             a_mode,
    output logic              a_gnt,
    input  logic              b_req,
    input  mode_t             b_mode,
    output logic              b_gnt,
    input  logic              gameover,
    input  logic              who,
    output logic              init,
    output logic [SEED_W-1:0] initial_val,
    output mode_t             control,
    output logic              busy,
    output logic              done,
    output logic              winner,
    output logic [SCORE_W-1:0] a_score,
    output logic [SCORE_W-1:0] b_score
);

    state_t              state, state_nxt;
    logic [DWELL_W-1:0]  dwell, dwell_d;
    logic [HOLD_W-1:0]   hold, hold_d;
    mode_t               control_d;
    logic [SEED_W-1:0]   initial_val_d;
    logic                winner_d;
    logic [SCORE_W-1:0]  a_score_d, b_score_d;
    logic                arb_en;
    logic [1:0]          arb_gnt;

    // Game over in the same cycle suppresses any grant.
    assign arb_en = (state == RUN) && !gameover && (dwell == DWELL_W'(MIN_DWELL));

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   ({b_req, a_req}),
        .en    (arb_en),
        .gnt   (arb_gnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        dwell_d       = dwell;
        hold_d        = hold;
        control_d     = control;
        initial_val_d = initial_val;
        winner_d      = winner;
        a_score_d     = a_score;
        b_score_d     = b_score;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt     = LOAD;
                    initial_val_d = start_seed;
                    control_d     = start_mode;
                end
            end
            LOAD: begin
                state_nxt = RUN;
                dwell_d   = '0;
            end
            RUN: begin
                if (gameover) begin
                    state_nxt = OVER;
                    hold_d    = '0;
                    winner_d  = who;
                    if (who) begin
                        if (b_score != '1) b_score_d = b_score + SCORE_W'(1);
                    end else begin
                        if (a_score != '1) a_score_d = a_score + SCORE_W'(1);
                    end
                end else if (arb_gnt != 2'b00) begin
                    control_d = arb_gnt[0] ? a_mode : b_mode;
                    dwell_d   = '0;
                end else if (dwell != DWELL_W'(MIN_DWELL)) begin
                    dwell_d = dwell + DWELL_W'(1);
                end
            end
            OVER: begin
                if (hold == HOLD_W'(OVER_HOLD - 1)) begin
                    state_nxt = IDLE;
                end else begin
                    hold_d = hold + HOLD_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next-state view so they align with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwell       <= '0;
            hold        <= '0;
            control     <= '0;
            initial_val <= '0;
            winner      <= 1'b0;
            a_score     <= '0;
            b_score     <= '0;
            init        <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            a_gnt       <= 1'b0;
            b_gnt       <= 1'b0;
        end else begin
            dwell       <= dwell_d;
            hold        <= hold_d;
            control     <= control_d;
            initial_val <= initial_val_d;
            winner      <= winner_d;
            a_score     <= a_score_d;
            b_score     <= b_score_d;
            init        <= (state_nxt == LOAD);
            busy        <= (state_nxt == LOAD) || (state_nxt == RUN);
            done        <= (state_nxt == OVER);
            a_gnt       <= arb_gnt[0];
            b_gnt       <= arb_gnt[1];
        end
    end

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer: stimulus queues expected events, a monitor pops and compares.
module tb_game_sequencer;

    localparam int K_INIT = 0;
    localparam int K_AGNT = 1;
    localparam int K_BGNT = 2;
    localparam int K_OVER = 3;
    localparam int K_DEND = 4;

    typedef struct {
        int kind;
        int cyc;
        int v0;
        int v1;
        int v2;
    } ev_t;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] start_seed;
    logic [1:0] start_mode;
    logic       a_req;
    logic [1:0] a_mode;
    logic       a_gnt;
    logic       b_req;
    logic [1:0] b_mode;
    logic       b_gnt;
    logic       gameover;
    logic       who;
    logic       init;
    logic [3:0] initial_val;
    logic [1:0] control;
    logic       busy;
    logic       done;
    logic       winner;
    logic [3:0] a_score;
    logic [3:0] b_score;

    ev_t sb[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  cyc      = 0;
    int  done_len = 0;
    bit  prev_done = 1'b0;

    game_sequencer #(
        .MIN_DWELL (4),
        .OVER_HOLD (8),
        .SCORE_W   (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .start_seed  (start_seed),
        .start_mode  (start_mode),
        .a_req       (a_req),
        .a_mode      (a_mode),
        .a_gnt       (a_gnt),
        .b_req       (b_req),
        .b_mode      (b_mode),
        .b_gnt       (b_gnt),
        .gameover    (gameover),
        .who         (who),
        .init        (init),
        .initial_val (initial_val),
        .control     (control),
        .busy        (busy),
        .done        (done),
        .winner      (winner),
        .a_score     (a_score),
        .b_score     (b_score)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input int c, input int v0, input int v1, input int v2);
        ev_t e;
        e.kind = kind; e.cyc = c; e.v0 = v0; e.v1 = v1; e.v2 = v2;
        sb.push_back(e);
    endtask

    task automatic observe(input int kind, input int v0, input int v1, input int v2);
        ev_t e;
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected: got kind=%0d v=%0d/%0d/%0d at cyc %0d, expected no event",
                     kind, v0, v1, v2, cyc);
        end else begin
            e = sb.pop_front();
            if (e.kind != kind || (e.cyc >= 0 && e.cyc != cyc) ||
                e.v0 != v0 || e.v1 != v1 || e.v2 != v2) begin
                n_fail++;
                $display("FAIL sb_event: got kind=%0d v=%0d/%0d/%0d at cyc %0d, expected kind=%0d v=%0d/%0d/%0d at cyc %0d",
                         kind, v0, v1, v2, cyc, e.kind, e.v0, e.v1, e.v2, e.cyc);
            end
        end
    endtask

    // Monitor: samples on the falling edge, away from DUT updates.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_done = 1'b0;
            done_len  = 0;
        end else begin
            check("gnt_onehot", int'(a_gnt & b_gnt), 0);
            if (done && !prev_done) observe(K_OVER, int'(winner), int'(a_score), int'(b_score));
            if (!done && prev_done) observe(K_DEND, done_len, 0, 0);
            if (init)  observe(K_INIT, int'(initial_val), int'(control), 0);
            if (a_gnt) observe(K_AGNT, int'(control), 0, 0);
            if (b_gnt) observe(K_BGNT, int'(control), 0, 0);
            done_len  = done ? done_len + 1 : 0;
            prev_done = done;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (!busy && !done) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_idle"}, int'(ok), 1);
    endtask

    task automatic wait_agnt(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (a_gnt) begin
                ok = 1'b1;
                break;
            end
        end
        a_req = 1'b0;
        check({tag, "_agnt_seen"}, int'(ok), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s, c, g, t, sp, exp_a;
        rst_n = 1'b0; start = 1'b0; start_seed = 4'h0; start_mode = 2'b00;
        a_req = 1'b0; a_mode = 2'b00; b_req = 1'b0; b_mode = 2'b00;
        gameover = 1'b0; who = 1'b0;

        #23;
        check("rst_init",    int'(init), 0);
        check("rst_control", int'(control), 0);
        check("rst_busy",    int'(busy), 0);
        check("rst_done",    int'(done), 0);
        check("rst_ival",    int'(initial_val), 0);
        check("rst_ascore",  int'(a_score), 0);
        check("rst_bscore",  int'(b_score), 0);
        check("rst_gnt",     int'({a_gnt, b_gnt}), 0);
        #4 rst_n = 1'b1;
        repeat (2) tick();

        // Start: seed 5, mode 2
        s = cyc;
        start = 1'b1; start_seed = 4'h5; start_mode = 2'b10;
        push(K_INIT, s + 1, 5, 2, 0);
        tick();
        start = 1'b0;
        check("load_busy", int'(busy), 1);
        tick();
        check("run_init_low", int'(init), 0);
        check("run_busy", int'(busy), 1);

        // Dwell: A requests from the first RUN cycle
        a_req = 1'b1; a_mode = 2'b01;
        push(K_AGNT, s + 7, 1, 0, 0);
        wait_agnt("dwell");

        // Contention: A was granted last, so B wins first
        c = cyc;
        a_req = 1'b1; a_mode = 2'b11; b_req = 1'b1; b_mode = 2'b10;
        push(K_BGNT, c + 5, 2, 0, 0);
        push(K_AGNT, c + 10, 3, 0, 0);
        for (int i = 0; i < 40; i++) begin
            tick();
            if (a_gnt) a_req = 1'b0;
            if (b_gnt) b_req = 1'b0;
            if (!a_req && !b_req) break;
        end
        check("contention_served", int'(a_req | b_req), 0);

        // Gameover beats an eligible A request
        a_req = 1'b1; a_mode = 2'b10;
        repeat (4) tick();
        g = cyc;
        gameover = 1'b1; who = 1'b1;
        push(K_OVER, g + 1, 1, 0, 1);
        push(K_DEND, -1, 8, 0, 0);
        tick();
        gameover = 1'b0; who = 1'b0;
        check("gameover_no_agnt", int'(a_gnt), 0);
        check("gameover_done", int'(done), 1);
        check("gameover_ctrl_held", int'(control), 3);
        wait_idle("over1");

        // Next game serves A's pending request after the dwell
        tick();
        t = cyc;
        start = 1'b1; start_seed = 4'h9; start_mode = 2'b00;
        push(K_INIT, t + 1, 9, 0, 0);
        push(K_AGNT, t + 7, 2, 0, 0);
        tick();
        start = 1'b0;
        wait_agnt("pending");

        // Asynchronous reset between clock edges in RUN
        repeat (2) tick();
        #2 rst_n = 1'b0;
        #1;
        check("arst_init",    int'(init), 0);
        check("arst_control", int'(control), 0);
        check("arst_busy",    int'(busy), 0);
        check("arst_bscore",  int'(b_score), 0);
        check("arst_ascore",  int'(a_score), 0);
        @(negedge clk);
        #1 rst_n = 1'b1;

        // 17 games won by A: score saturates at 15
        for (int k = 1; k <= 17; k++) begin
            tick();
            sp = cyc;
            start = 1'b1;
            start_seed = (k == 1) ? 4'h5 : 4'(k);
            start_mode = (k == 1) ? 2'b10 : 2'(k);
            push(K_INIT, sp + 1, (k == 1) ? 5 : (k % 16), (k == 1) ? 2 : (k % 4), 0);
            tick();
            start = 1'b0;
            if (k == 1) check("rerun_busy", int'(busy), 1);
            tick();
            gameover = 1'b1; who = 1'b0;
            exp_a = (k > 15) ? 15 : k;
            push(K_OVER, sp + 3, 0, exp_a, 0);
            push(K_DEND, -1, 8, 0, 0);
            tick();
            gameover = 1'b0;
            wait_idle("sat");
        end
        check("sat_ascore", int'(a_score), 15);
        check("sat_bscore", int'(b_score), 0);

        for (int i = 0; i < 20; i++) begin
            if (sb.size() == 0) break;
            tick();
        end
        check("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
